// File: rtl/alarm_keypad_ctrl_if.sv
// rtl/alarm_keypad_ctrl_if.sv - key stream, alarm state and command/status bundle for the keypad front end
interface alarm_keypad_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [1:0] alarm_state;
    logic       arm_cmd;
    logic       disarm_cmd;
    logic       bad_code;
    logic       lockout;
    logic       entry_active;
    logic [2:0] digit_count;

    modport master (
        output key_valid, key_code, alarm_state,
        input  arm_cmd, disarm_cmd, bad_code, lockout, entry_active, digit_count
    );

    modport slave (
        input  key_valid, key_code, alarm_state,
        output arm_cmd, disarm_cmd, bad_code, lockout, entry_active, digit_count
    );
endinterface

// File: rtl/alarm_keypad_ctrl.sv
// rtl/alarm_keypad_ctrl.sv - PIN entry, arm/disarm command generation and bad-code lockout
module alarm_keypad_ctrl #(
    parameter int                    CODE_LEN       = 4,
    parameter logic [4*CODE_LEN-1:0] PIN            = 16'h1234,
    parameter int                    ENTRY_TIMEOUT  = 1000,
    parameter int                    MAX_FAILS      = 3,
    parameter int                    LOCKOUT_CYCLES = 5000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    alarm_keypad_ctrl_if.slave   kp
);
    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CHECK, S_LOCKOUT} state_t;

    localparam int PW  = 4 * CODE_LEN;
    localparam int ETW = (ENTRY_TIMEOUT > 1) ? $clog2(ENTRY_TIMEOUT) : 1;
    localparam int LTW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int FW  = (MAX_FAILS > 0) ? $clog2(MAX_FAILS + 1) : 1;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;

    state_t          state_q, state_d;
    logic [PW-1:0]   code_q, code_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [ETW-1:0]  et_q, et_d;
    logic [LTW-1:0]  lt_q, lt_d;
    logic [FW-1:0]   fail_q, fail_d;
    logic [FW-1:0]   fail_inc;
    logic            arm_q, arm_d;
    logic            dis_q, dis_d;
    logic            bad_q, bad_d;
    logic            lock_q, lock_d;
    logic            act_q, act_d;
    logic            is_digit;
    logic            match;

    assign is_digit = (kp.key_code <= 4'd9);
    assign match    = (cnt_q == 3'(CODE_LEN)) && !ovf_q && (code_q == PIN);
    assign fail_inc = fail_q + FW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            et_q    <= '0;
            lt_q    <= '0;
            fail_q  <= '0;
            arm_q   <= 1'b0;
            dis_q   <= 1'b0;
            bad_q   <= 1'b0;
            lock_q  <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            et_q    <= et_d;
            lt_q    <= lt_d;
            fail_q  <= fail_d;
            arm_q   <= arm_d;
            dis_q   <= dis_d;
            bad_q   <= bad_d;
            lock_q  <= lock_d;
            act_q   <= act_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        et_d    = et_q;
        lt_d    = lt_q;
        fail_d  = fail_q;
        arm_d   = 1'b0;
        dis_d   = 1'b0;
        bad_d   = 1'b0;

        // With ena low everything holds; only the pulse registers fall back to 0.
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (kp.key_valid && is_digit) begin
                        code_d  = PW'(kp.key_code);
                        cnt_d   = 3'd1;
                        ovf_d   = 1'b0;
                        et_d    = '0;
                        state_d = S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (kp.key_valid) begin
                        et_d = '0;
                        if (is_digit) begin
                            if (cnt_q < 3'(CODE_LEN)) begin
                                code_d = (code_q << 4) | PW'(kp.key_code);
                                cnt_d  = cnt_q + 3'd1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end else if (kp.key_code == KEY_CLEAR) begin
                            code_d  = '0;
                            cnt_d   = '0;
                            ovf_d   = 1'b0;
                            state_d = S_IDLE;
                        end else if (kp.key_code == KEY_ENTER) begin
                            state_d = S_CHECK;
                        end
                    end else if (et_q == ETW'(ENTRY_TIMEOUT - 1)) begin
                        code_d  = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        et_d    = '0;
                        state_d = S_IDLE;
                    end else begin
                        et_d = et_q + ETW'(1);
                    end
                end
                S_CHECK: begin
                    code_d = '0;
                    cnt_d  = '0;
                    ovf_d  = 1'b0;
                    et_d   = '0;
                    if (match) begin
                        arm_d   = (kp.alarm_state == 2'b00);
                        dis_d   = (kp.alarm_state != 2'b00);
                        fail_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        bad_d  = 1'b1;
                        fail_d = fail_inc;
                        lt_d   = '0;
                        state_d = (fail_inc == FW'(MAX_FAILS)) ? S_LOCKOUT : S_IDLE;
                    end
                end
                S_LOCKOUT: begin
                    if (lt_q == LTW'(LOCKOUT_CYCLES - 1)) begin
                        lt_d    = '0;
                        fail_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        lt_d = lt_q + LTW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        lock_d = (state_d == S_LOCKOUT);
        act_d  = (state_d == S_ENTRY);
    end

    assign kp.arm_cmd      = arm_q;
    assign kp.disarm_cmd   = dis_q;
    assign kp.bad_code     = bad_q;
    assign kp.lockout      = lock_q;
    assign kp.entry_active = act_q;
    assign kp.digit_count  = cnt_q;
endmodule

// File: doc/alarm_keypad_ctrl.md
Name: alarm_keypad_ctrl

Overview:
Keypad front end that produces the command inputs for the alarm state machine (OFF/ARMED/TRIGGERED/ALARM_ON).
- Collects key codes and verifies a fixed PIN.
- Issues one-cycle arm/disarm command pulses, choosing between them from the alarm's current state.
- Counts consecutive bad codes and locks the keypad out for a fixed period after MAX_FAILS failures.

Parameters:
CODE_LEN, 4, digits per PIN (1..6).
PIN, 16'h1234, expected code, 4*CODE_LEN bits; first key entered is the most significant nibble.
ENTRY_TIMEOUT, 1000, clk cycles with no accepted key before a partial entry is discarded.
MAX_FAILS, 3, consecutive bad codes that trigger lockout.
LOCKOUT_CYCLES, 5000, length of lockout in clk cycles.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
ena  input  1  design enable; when low, keys are ignored and all state/timers hold
key_valid  input  1  one-cycle strobe, key_code valid
key_code  input  4  0x0-0x9 digit, 0xA ENTER, 0xB CLEAR, 0xC-0xF ignored
alarm_state  input  2  current alarm FSM state: 00 OFF, 01 ARMED, 10 TRIGGERED, 11 ALARM_ON
arm_cmd  output  1  one-cycle pulse: request OFF->ARMED
disarm_cmd  output  1  one-cycle pulse: request return to OFF
bad_code  output  1  one-cycle pulse: rejected code
lockout  output  1  high for the whole LOCKOUT state
entry_active  output  1  high in ENTRY
digit_count  output  3  digits accepted in current entry, saturates at CODE_LEN

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; all outputs 0; buffer, digit_count, overflow flag, timers and fail_count cleared. Reset applies mid-entry and mid-lockout alike.
- State machine states: IDLE, ENTRY, CHECK, LOCKOUT. All outputs are registered.
- IDLE:
  - Digit: load it as the first nibble, digit_count=1, timer cleared, go to ENTRY.
  - ENTER, CLEAR, 0xC-0xF: ignored.
- ENTRY:
  - Digit with digit_count<CODE_LEN: shift the nibble in, digit_count+1.
  - Digit with digit_count=CODE_LEN: set overflow; buffer and count unchanged.
  - Every accepted key (any code, including ignored codes) resets the timer.
  - CLEAR: discard the entry, go to IDLE; no fail is counted.
  - ENTER: go to CHECK.
  - Timer reaching ENTRY_TIMEOUT-1 with no key: discard the entry, go to IDLE; no fail is counted.
- CHECK: lasts exactly one cycle; key_valid is ignored.
  - Match condition: digit_count==CODE_LEN, overflow==0, and buffer==PIN.
  - Match with alarm_state==OFF: arm_cmd=1 for one cycle.
  - Match with any other alarm_state: disarm_cmd=1 for one cycle.
  - On match: fail_count=0, go to IDLE.
  - Mismatch: bad_code=1 for one cycle, fail_count+1. Go to LOCKOUT if the new count equals MAX_FAILS, otherwise go to IDLE.
- Latency: ENTER sampled at edge k, CHECK after edge k, command/bad_code pulse visible after edge k+1, next state after edge k+1.
- LOCKOUT:
  - lockout=1 from the edge after the CHECK pulse.
  - All keys are ignored.
  - After LOCKOUT_CYCLES cycles: lockout=0, fail_count=0, state IDLE.
- Outputs arm_cmd, disarm_cmd and bad_code are mutually exclusive; at most one is high in any cycle.
- digit_count is cleared whenever the block leaves ENTRY/CHECK.
- ena low: inputs ignored, state/timers/outputs frozen, except that pulses still deassert after one cycle.
- Timer widths: $clog2 of the respective parameter, with no wrap before the terminal count.

Test Plan:
- Reset, alarm_state=00, keys 1,2,3,4,ENTER -> arm_cmd high exactly one cycle, two edges after ENTER; digit_count 1..4 then 0; no bad_code.
- alarm_state=11, keys 1,2,3,4,ENTER -> disarm_cmd single pulse, arm_cmd stays 0; repeat with alarm_state=01 and 10 -> disarm_cmd.
- Keys 1,2,3,5,ENTER -> bad_code one pulse. Keys 1,2,3,ENTER (short) and 1,2,3,4,5,ENTER (overflow) -> bad_code each. That makes three consecutive fails -> lockout=1. With LOCKOUT_CYCLES=20: lockout stays high 20 cycles, a correct code entered during lockout produces nothing, and a correct code after lockout -> arm_cmd.
- Fail, fail, correct code -> command pulse and fail_count cleared; a subsequent single fail -> bad_code but no lockout.
- ENTRY_TIMEOUT=10: keys 1,2 then 10 idle cycles -> return to IDLE, digit_count=0. Then 3,4,ENTER -> bad_code (no carry-over of the old digits). Also keys 1,2,CLEAR,1,2,3,4,ENTER -> arm_cmd.
- Keys 1,2, rst_n low one cycle, then 3,4,ENTER -> bad_code. ena low while keys 1,2,3,4,ENTER are strobed -> no output. Raise ena and replay the sequence -> arm_cmd.
